// File: rtl/guard_pkg.sv
// Shared types and constants for the redundant output guard.
// States, status codes and the safe drive levels live here.
package guard_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    ERROR,
    LOCK
  } state_t;

  localparam logic [1:0] ST_WAIT = 2'b10;
  localparam logic [1:0] ST_PASS = 2'b00;
  localparam logic [1:0] ST_ERR  = 2'b01;
  localparam logic [1:0] ST_LOCK = 2'b11;

  localparam logic SAFE_RELAY = 1'b1;

  // The switch idles opposite to the drive polarity.
  function automatic logic safe_switch(input logic order);
    return ~order;
  endfunction

endpackage

// File: rtl/guard_watchdog.sv
// Watchdog for the guard: counts silent cycles while enabled.
// expire is high once the count sits at TIMEOUT_CYC-1.
module guard_watchdog
  import guard_pkg::*;
#(
  parameter int TIMEOUT_CYC = 10000000,
  parameter int CNT_W       = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt;

  assign expire = (cnt == LAST);

  // Holds at LAST so the counter can never wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !expire) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/redundant_output_guard.sv
// Redundant output guard: arbitrates N_MOD compare channels, gates drive.
// Build option GUARD_UNLOCK_EN lets an unlock pulse leave LOCK.
module redundant_output_guard
  import guard_pkg::*;
#(
  parameter int N_MOD       = 2,
  parameter int ERR_LIMIT   = 3,
  parameter int TIMEOUT_CYC = 10000000,
  parameter int CNT_W       = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         order,
  input  logic                         cmp_valid,
  input  logic [N_MOD-1:0]             mismatch,
  input  logic                         ref_a,
  input  logic                         ref_b,
  input  logic                         unlock,
  output logic [1:0]                   status,
  output logic                         relay_ctrl,
  output logic                         switch_ctrl,
  output logic [$clog2(ERR_LIMIT+1)-1:0] err_cnt,
  output logic                         timeout_flag,
  output logic                         locked
);

  localparam int EW = $clog2(ERR_LIMIT + 1);
  localparam logic [EW-1:0] LIMIT = EW'(ERR_LIMIT);

  state_t state, state_n;
  logic [EW-1:0] err_inc;
  logic any_mm;
  logic wd_clr, wd_en, wd_exp;
  logic to_lock, do_unlock;

  assign any_mm = |mismatch;

  always_comb begin
    err_inc = err_cnt;
    if (err_cnt < LIMIT) err_inc = err_cnt + EW'(1);
  end

`ifdef GUARD_UNLOCK_EN
  assign do_unlock = (state == LOCK) && unlock;
`else
  logic unused_unlock;
  assign unused_unlock = unlock;
  assign do_unlock = 1'b0;
`endif

  always_comb begin
    state_n = state;
    to_lock = 1'b0;
    unique case (state)
      IDLE: begin
        if (cmp_valid) state_n = any_mm ? ERROR : ACTIVE;
      end
      ACTIVE: begin
        // A compare in the expiry cycle beats the timeout.
        if (cmp_valid) begin
          if (any_mm) state_n = ERROR;
        end else if (wd_exp) begin
          state_n = LOCK;
          to_lock = 1'b1;
        end
      end
      ERROR: begin
        state_n = (err_inc >= LIMIT) ? LOCK : IDLE;
      end
      LOCK: begin
        if (do_unlock) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign wd_en  = (state == ACTIVE) && !cmp_valid;
  assign wd_clr = ((state_n == ACTIVE) && ((state != ACTIVE) || cmp_valid))
                || do_unlock;

  guard_watchdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .CNT_W       (CNT_W)
  ) u_wd (
    .clk    (clk),
    .rst    (rst),
    .clr    (wd_clr),
    .en     (wd_en),
    .expire (wd_exp)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      err_cnt      <= '0;
      timeout_flag <= 1'b0;
      relay_ctrl   <= SAFE_RELAY;
      switch_ctrl  <= safe_switch(order);
    end else begin
      state <= state_n;
      if (state == ERROR) err_cnt <= err_inc;
      if (to_lock) timeout_flag <= 1'b1;
      if (do_unlock) begin
        err_cnt      <= '0;
        timeout_flag <= 1'b0;
      end
      // Keyed on the next state so ERROR/LOCK are safe from their first cycle.
      if (state_n == ACTIVE) begin
        relay_ctrl  <= ref_a ^ order;
        switch_ctrl <= ref_b ^ order;
      end else begin
        relay_ctrl  <= SAFE_RELAY;
        switch_ctrl <= safe_switch(order);
      end
    end
  end

  always_comb begin
    status = ST_WAIT;
    unique case (state)
      IDLE:    status = ST_WAIT;
      ACTIVE:  status = ST_PASS;
      ERROR:   status = ST_ERR;
      LOCK:    status = ST_LOCK;
      default: status = ST_WAIT;
    endcase
  end

  assign locked = (state == LOCK);

endmodule
